// File: rtl/pipe_controller.sv
// pipe_controller: single-stage control decode with a HALT drain FSM and a
// saturating retired-instruction counter. One cycle of latency throughout.
// Optional build macro: PIPE_LUI_AUIPC_EN adds LUI/AUIPC decode; when it is
// undefined those opcodes are illegal and AuipcSel stays 0.
module pipe_controller #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             JalrSel,
    output logic             Jump,
    output logic             AuipcSel,
    output logic [1:0]       ALUOp,
    output logic             out_valid,
    output logic             HaltOut,
    output logic             Illegal,
    output logic             fetch_stop,
    output logic             Halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;
`ifdef PIPE_LUI_AUIPC_EN
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jalr_sel;
        logic       jump;
        logic       auipc_sel;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t     state;
    logic [3:0] drain_cnt;
    ctrl_t      ctrl_q;
    ctrl_t      dec;
    logic       dec_ok;
    logic       accept;
    logic       is_halt;
    logic       issue;

    // Opcode decode into a control bundle plus a "recognised" flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        dec    = '0;
        dec_ok = 1'b1;
        case (Opcode)
            OP_R:    begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
            OP_I:    begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
            OP_LW:   begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_op     = 2'b00;
            end
            OP_SW:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 2'b00; end
            OP_BR:   begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
            OP_JAL:  begin dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_op = 2'b10; end
            OP_JALR: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.jalr_sel  = 1'b1;
                dec.alu_op    = 2'b10;
            end
`ifdef PIPE_LUI_AUIPC_EN
            OP_LUI:  begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; end
            OP_AUIPC: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.auipc_sel = 1'b1;
                dec.alu_op    = 2'b11;
            end
`else
            // LUI and AUIPC have no entry here and take the illegal path.
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    // Qualify the incoming instruction: only RUN, valid and unflushed slots are considered.
    always_comb begin
        accept  = (state == ST_RUN) && in_valid && !flush;
        is_halt = accept && (Opcode == OP_HALT);
        issue   = is_halt || (accept && dec_ok);
    end

    // Registered bundle, FSM, drain counter and retired counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
        if (!reset) begin
            ctrl_q     <= '0;
            out_valid  <= 1'b0;
            HaltOut    <= 1'b0;
            Illegal    <= 1'b0;
            fetch_stop <= 1'b0;
            Halted     <= 1'b0;
            retired    <= '0;
            drain_cnt  <= '0;
            state      <= ST_RUN;
        end else if (!stall) begin
            // Default to a bubble; the accepted cases below override it.
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            HaltOut   <= 1'b0;
            Illegal   <= 1'b0;

            if (is_halt) begin
                out_valid  <= 1'b1;
                HaltOut    <= 1'b1;
                fetch_stop <= 1'b1;
                state      <= ST_DRAIN;
                drain_cnt  <= 4'(DRAIN_CYCLES - 1);
            end else if (accept && dec_ok) begin
                ctrl_q    <= dec;
                out_valid <= 1'b1;
            end else if (accept) begin
                Illegal <= 1'b1;
            end

            if (issue && (retired != '1)) begin
                retired <= retired + CNT_W'(1);
            end

            if (state == ST_DRAIN) begin
                if (drain_cnt == '0) begin
                    state  <= ST_HALTED;
                    Halted <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt - 4'd1;
                end
            end
        end else if (flush) begin
            // Stalled flush still squashes the bundle; FSM and counters stay frozen.
            ctrl_q    <= '0;
            out_valid <= 1'b0;
            HaltOut   <= 1'b0;
            Illegal   <= 1'b0;
        end
    end

    assign ALUSrc   = ctrl_q.alu_src;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign JalrSel  = ctrl_q.jalr_sel;
    assign Jump     = ctrl_q.jump;
    assign AuipcSel = ctrl_q.auipc_sel;
    assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed scenarios plus randomized traffic, checked by a
// scoreboard against a cycle-level behavioural model of the controller.
module tb_pipe_controller;

    localparam int DRAIN   = 4;
    localparam int CW      = 8;
    localparam int RET_MAX = (1 << CW) - 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    Opcode;
    logic          in_valid, stall, flush;
    logic          ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, Jump, AuipcSel;
    logic [1:0]    ALUOp;
    logic          out_valid, HaltOut, Illegal, fetch_stop, Halted;
    logic [CW-1:0] retired;

    pipe_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .in_valid(in_valid),
        .stall(stall), .flush(flush),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .JalrSel(JalrSel), .Jump(Jump),
        .AuipcSel(AuipcSel), .ALUOp(ALUOp), .out_valid(out_valid), .HaltOut(HaltOut),
        .Illegal(Illegal), .fetch_stop(fetch_stop), .Halted(Halted), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Decode table, bit order: ALUSrc MemtoReg RegWrite MemRead MemWrite Branch JalrSel Jump AuipcSel ALUOp[1:0]
    logic [10:0] dec_tbl [logic [6:0]];

    // Model state: visible outputs plus "halt seen" and unstalled cycles since it.
    logic [10:0] m_ctrl;
    logic        m_ov, m_ho, m_ill, m_fs, m_halted;
    int          m_ret;
    bit          halting;
    int          since;

    logic [23:0] exp_q [$];

    function automatic logic [23:0] model_vec();
        return {m_ctrl, m_ov, m_ho, m_ill, m_fs, m_halted, CW'(m_ret)};
    endfunction

    task automatic bump();
        if (m_ret < RET_MAX) m_ret++;
    endtask

    task automatic bubble();
        m_ctrl = '0;
        m_ov   = 1'b0;
        m_ho   = 1'b0;
        m_ill  = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic [6:0] op, input logic v,
                              input logic s, input logic f);
        bit was;
        if (!r) begin
            bubble();
            m_fs = 1'b0; m_halted = 1'b0; m_ret = 0; halting = 1'b0; since = 0;
        end else if (s) begin
            if (f) bubble();
        end else begin
            was = halting;
            bubble();
            if (was) begin
                since++;
            end else if (v && !f) begin
                if (op == OP_HALT) begin
                    m_ov = 1'b1; m_ho = 1'b1; bump(); halting = 1'b1; since = 0;
                end else if (dec_tbl.exists(op)) begin
                    m_ctrl = dec_tbl[op]; m_ov = 1'b1; bump();
                end else begin
                    m_ill = 1'b1;
                end
            end
            m_fs     = halting;
            m_halted = halting && (since >= DRAIN);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] op, input logic v,
                        input logic s, input logic f);
        @(negedge clk);
        reset = r; Opcode = op; in_valid = v; stall = s; flush = f;
        model_step(r, op, v, s, f);
        @(posedge clk);
        exp_q.push_back(model_vec());
    endtask

    // Monitor: one registered bundle per cycle, compared against the oldest expectation.
    initial begin
        logic [23:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            cycle++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, Jump,
                         AuipcSel, ALUOp, out_valid, HaltOut, Illegal, fetch_stop, Halted, retired};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL bundle cycle=%0d got=%h exp=%h (ctrl/ov/ho/ill/fs/halted/retired)",
                             cycle, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] pool [10];
        logic [6:0] opc;
        int         k;
        logic       rr, vv, ss, ff;

        dec_tbl[OP_R]    = {9'b001000000, 2'b10};
        dec_tbl[OP_I]    = {9'b101000000, 2'b10};
        dec_tbl[OP_LW]   = {9'b111100000, 2'b00};
        dec_tbl[OP_SW]   = {9'b100010000, 2'b00};
        dec_tbl[OP_BR]   = {9'b000001000, 2'b01};
        dec_tbl[OP_JAL]  = {9'b001000010, 2'b10};
        dec_tbl[OP_JALR] = {9'b101000100, 2'b10};
`ifdef PIPE_LUI_AUIPC_EN
        dec_tbl[OP_LUI]   = {9'b101000000, 2'b11};
        dec_tbl[OP_AUIPC] = {9'b101000001, 2'b11};
`endif
        pool = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b0000000};

        reset = 1'b0; Opcode = '0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;

        // Reset, then a single LW.
        step(0, OP_R, 1, 1, 1);
        step(1, '0, 0, 0, 0);
        step(1, OP_LW, 1, 0, 0);
        // R, then BR held under stall for three cycles, then released.
        step(1, OP_R, 1, 0, 0);
        repeat (3) step(1, OP_BR, 1, 1, 0);
        step(1, OP_BR, 1, 0, 0);
        // Flushed SW and flushed HALT.
        step(1, OP_SW, 1, 0, 1);
        step(1, OP_HALT, 1, 0, 1);
        // LUI/AUIPC, an unlisted opcode, remaining decodes.
        step(1, OP_LUI, 1, 0, 0);
        step(1, OP_AUIPC, 1, 0, 0);
        step(1, 7'b0001111, 1, 0, 0);
        step(1, OP_I, 1, 0, 0);
        step(1, OP_JAL, 1, 0, 0);
        step(1, OP_JALR, 1, 0, 0);
        // Stall together with flush squashes the held bundle.
        step(1, OP_R, 1, 1, 1);
        step(1, OP_R, 0, 0, 0);
        // HALT with a stall inside the drain window, then traffic while halted.
        step(1, OP_HALT, 1, 0, 0);
        step(1, OP_R, 1, 0, 0);
        step(1, OP_R, 1, 1, 0);
        repeat (6) step(1, OP_R, 1, 0, 0);
        // Reset aborts HALTED; HALT again and reset mid-drain.
        step(0, OP_R, 1, 0, 0);
        step(1, OP_HALT, 1, 0, 0);
        step(1, OP_R, 1, 0, 0);
        step(0, OP_R, 1, 1, 0);
        step(1, OP_R, 0, 0, 0);
        // Saturation: 260 valid R opcodes.
        repeat (260) step(1, OP_R, 1, 0, 0);
        step(1, OP_SW, 1, 0, 0);
        step(0, OP_R, 0, 0, 0);

        // Randomized traffic with occasional resets to leave HALTED.
        for (int i = 0; i < 1500; i++) begin
            k   = int'($urandom_range(0, 99));
            opc = pool[$urandom_range(0, 9)];
            if (k < 3) opc = OP_HALT;
            else if (k < 8) opc = 7'($urandom);
            rr = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            vv = ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0;
            ss = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
            ff = ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0;
            step(rr, opc, vv, ss, ff);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_scoreboard pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_controller.md
PIPE_CONTROLLER -- requirements
Module: pipe_controller

Interface
REQ-001 Parameters SHALL be: DRAIN_CYCLES, default 4, cycles from HALT accept to Halted, legal 1..15; CNT_W, default 32, retired-instruction counter width, legal 8..64.
REQ-002 clk input 1 SHALL be the single clock; all state updates on rising edge.
REQ-003 reset input 1 SHALL be the reset: synchronous and active-low.
REQ-004 Opcode input 7 SHALL carry the instruction opcode field.
REQ-005 in_valid input 1 SHALL mark Opcode as a real instruction.
REQ-006 stall input 1 SHALL hold all registered outputs and state.
REQ-007 flush input 1 SHALL replace the next registered bundle with a bubble.
REQ-008 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, JalrSel, Jump, AuipcSel outputs 1 each SHALL be the registered control bundle.
REQ-009 ALUOp output 2 SHALL be the registered ALU operation class.
REQ-010 out_valid output 1 SHALL mark the bundle as a real instruction.
REQ-011 HaltOut output 1 SHALL pulse with the registered HALT instruction; Illegal output 1 SHALL flag an undecoded valid opcode.
REQ-012 fetch_stop output 1 SHALL request fetch to stop; Halted output 1 SHALL mark the terminal state.
REQ-013 retired output CNT_W SHALL count bundles issued with out_valid=1.

Function
REQ-014 Decode SHALL be: R 0110011 RegWrite, ALUOp=10; I 0010011 ALUSrc, RegWrite, ALUOp=10; LW 0000011 ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp=00; SW 0100011 ALUSrc, MemWrite, ALUOp=00; BR 1100011 Branch, ALUOp=01; JAL 1101111 RegWrite, Jump, ALUOp=10; JALR 1100111 ALUSrc, RegWrite, JalrSel, ALUOp=10; unlisted signals 0.
REQ-015 Latency SHALL be one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-016 FSM states SHALL be RUN, DRAIN, HALTED; reset enters RUN.
REQ-017 In RUN with stall=0, flush=0, in_valid=1 and a decoded non-HALT opcode, the decoded bundle SHALL load with out_valid=1 and retired SHALL increment.
REQ-018 A bubble (all bundle bits, ALUOp, out_valid, HaltOut, Illegal = 0) SHALL load when stall=0 and any of: flush=1, in_valid=0, state not RUN.
REQ-019 stall=1 SHALL freeze bundle, FSM, drain counter and retired; stall=1 with flush=1 SHALL resolve as flush (bubble loads, FSM and counter still frozen).
REQ-020 HALT 1111111 accepted in RUN SHALL load a zero bundle with out_valid=1, HaltOut=1, increment retired, enter DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-021 HALT coinciding with flush=1 SHALL be discarded; state stays RUN.
REQ-022 fetch_stop SHALL be 1 in DRAIN and HALTED, 0 in RUN, registered with the state.
REQ-023 In DRAIN, each unstalled cycle SHALL decrement the counter; on counter 0, next state SHALL be HALTED, with DRAIN_CYCLES=1 reaching HALTED one cycle after HaltOut.
REQ-024 HALTED SHALL persist until reset, with Halted=1 and only bubbles issued.
REQ-025 A valid unlisted opcode in RUN (unstalled, unflushed) SHALL load a bubble with Illegal=1 for that bundle, without incrementing retired.
REQ-026 retired SHALL saturate at all-ones, not wrap.

Reset
REQ-027 reset=0 at a rising edge SHALL set all outputs to 0, retired to 0, drain counter to 0 and state to RUN, overriding stall and flush and aborting DRAIN or HALTED.

Configuration
REQ-028 With PIPE_LUI_AUIPC_EN defined, LUI 0110111 SHALL decode ALUSrc, RegWrite, ALUOp=11, and AUIPC 0010111 SHALL decode the same plus AuipcSel=1.
REQ-029 Without PIPE_LUI_AUIPC_EN, both opcodes SHALL be illegal per REQ-025 and AuipcSel SHALL be constant 0.

Verification
REQ-030 Reset then LW valid -> next cycle ALUSrc=MemtoReg=RegWrite=MemRead=1, ALUOp=00, out_valid=1, retired=1.
REQ-031 BR valid with stall=1 for 3 cycles after the prior R bundle -> R bundle held 3 cycles, retired unchanged; stall released -> Branch=1, ALUOp=01.
REQ-032 SW valid with flush=1 -> bubble, retired unchanged; HALT with flush=1 -> state stays RUN, fetch_stop=0.
REQ-033 HALT with DRAIN_CYCLES=4 -> HaltOut=1 for 1 cycle, fetch_stop=1, Halted=1 exactly 4 cycles after HaltOut; later R valid -> bubble.
REQ-034 Opcode 0110111 valid -> with PIPE_LUI_AUIPC_EN: RegWrite=1, ALUOp=11; without: Illegal=1, out_valid=0.
REQ-035 CNT_W=8, 260 valid R opcodes -> retired=255; reset=0 during DRAIN -> RUN, fetch_stop=0, retired=0.
